// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the sequential binary-to-BCD conversion scheduler.
package bcd_sched_pkg;
  localparam int BIN_W      = 16;
  localparam int DIGITS     = 5;
  localparam int BCD_W      = 20;
  localparam int SHIFT_LAST = 15;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bcd_rr_arbiter.sv
// Round-robin grant: search starts one past the last-granted requester.
module bcd_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            take,
  output logic            gnt_vld,
  output logic [1:0]      gnt_idx
);
  logic [1:0] ptr;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr;
    for (int i = NREQ; i >= 1; i--) begin
      for (int k = 0; k < NREQ; k++) begin
        if (req[k] && (k == (int'(ptr) + i) % NREQ)) begin
          gnt_vld = 1'b1;
          gnt_idx = 2'(k);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ptr <= 2'(NREQ - 1);
    else if (take && gnt_vld)  ptr <= gnt_idx;
  end
endmodule

// File: rtl/bcd_convert_scheduler.sv
// Shared shift-and-add-3 binary-to-BCD engine, one bit per cycle, fronted by a
// round-robin arbiter; one conversion per 18 cycles under continuous load.
module bcd_convert_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_i,
  input  logic [16*NREQ-1:0]    value_i,
  output logic [NREQ-1:0]       ack_o,
  output logic                  done_o,
  output logic [1:0]            result_id_o,
  output logic [BCD_W-1:0]      bcd_o,
  output logic                  busy_o
);
  localparam int SH_W = BCD_W + BIN_W;

  state_t            state, state_nxt;
  logic [SH_W-1:0]   sh, sh_adj, sh_nxt;
  logic [3:0]        cnt;
  logic [1:0]        gid;
  logic              gnt_vld, take;
  logic [1:0]        gnt_idx;
  logic [BIN_W-1:0]  val_sel;

  bcd_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_i),
    .take    (take),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    val_sel = '0;
    for (int k = 0; k < NREQ; k++)
      if (gnt_idx == 2'(k)) val_sel = value_i[16*k +: 16];
  end

  // Add-3 on every digit nibble >= 5, then shift the whole {digits, operand} left.
  always_comb begin
    sh_adj = sh;
    for (int d = 0; d < DIGITS; d++)
      if (sh[BIN_W+4*d +: 4] >= 4'd5)
        sh_adj[BIN_W+4*d +: 4] = sh[BIN_W+4*d +: 4] + 4'd3;
    sh_nxt = sh_adj << 1;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE:  if (gnt_vld) begin
               take      = 1'b1;
               state_nxt = SHIFT;
             end
      SHIFT: if (cnt == 4'(SHIFT_LAST)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sh          <= '0;
      cnt         <= '0;
      gid         <= '0;
      bcd_o       <= '0;
      result_id_o <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (take) begin
          sh  <= {{BCD_W{1'b0}}, val_sel};
          cnt <= '0;
          gid <= gnt_idx;
        end
        SHIFT: begin
          sh  <= sh_nxt;
          cnt <= cnt + 4'd1;
          // Result registers load on the last shift so they are valid throughout DONE.
          if (cnt == 4'(SHIFT_LAST)) begin
            bcd_o       <= sh_nxt[SH_W-1 -: BCD_W];
            result_id_o <= gid;
          end
        end
        default: ;
      endcase
    end
  end

  assign done_o = (state == DONE);
  assign busy_o = (state != IDLE);

  always_comb begin
    ack_o = '0;
    for (int k = 0; k < NREQ; k++)
      ack_o[k] = done_o && (gid == 2'(k));
  end
endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Scoreboard bench: drivers push expected {id, bcd}; a negedge monitor pops on done_o.
module tb_bcd_convert_scheduler;
  localparam int NREQ = 2;
  localparam int LAT_MAX = NREQ * 18;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_i;
  logic [16*NREQ-1:0]   value_i;
  logic [NREQ-1:0]      ack_o;
  logic                 done_o;
  logic [1:0]           result_id_o;
  logic [19:0]          bcd_o;
  logic                 busy_o;

  bcd_convert_scheduler #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .value_i     (value_i),
    .ack_o       (ack_o),
    .done_o      (done_o),
    .result_id_o (result_id_o),
    .bcd_o       (bcd_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {int id; logic [19:0] bcd;} exp_t;
  exp_t q[$];
  exp_t e;
  int   ncmp = 0, nerr = 0, cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    ncmp++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Reference via repeated division, independent of the shift-add-3 structure.
  function automatic logic [19:0] ref_bcd(int v);
    logic [19:0] r;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (done_o) begin
        if (q.size() == 0) begin
          ncmp++; nerr++;
          $display("FAIL unexpected_done: got bcd %0h id %0d expected no result", bcd_o, result_id_o);
        end else begin
          e = q.pop_front();
          chk("bcd", 32'(bcd_o), 32'(e.bcd));
          chk("result_id", 32'(result_id_o), 32'(e.id));
          chk("ack_onehot", 32'(ack_o), 32'(1) << e.id);
        end
      end else if (ack_o != '0) begin
        chk("ack_without_done", 32'(ack_o), 32'd0);
      end
    end
  end

  task automatic wait_ack(int k, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack_o[k] && lat < LAT_MAX + 4);
    if (!ack_o[k]) begin
      ncmp++; nerr++;
      $display("FAIL ack_timeout: got no ack for req %0d expected within %0d cycles", k, LAT_MAX);
    end
  endtask

  // Caller is #1 past a posedge; req drops on the edge following ack.
  task automatic req1(int k, logic [15:0] v, logic [19:0] want, output int lat);
    value_i[16*k +: 16] = v;
    q.push_back('{k, want});
    req_i[k] = 1'b1;
    wait_ack(k, lat);
    @(posedge clk); #1;
    req_i[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  int lat, bnd;
  int tack[3];
  logic [15:0] xv[4]   = '{16'd0, 16'd65535, 16'd999, 16'd10000};
  logic [19:0] xw[4]   = '{20'h00000, 20'h65535, 20'h00999, 20'h10000};

  initial begin
    rst_n = 1'b0; req_i = '0; value_i = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_bcd", 32'(bcd_o), 0);
    chk("rst_id", 32'(result_id_o), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    req1(0, 16'd1234, 20'h01234, lat);
    chk("latency", lat, 18);

    for (int i = 0; i < 4; i++) req1((i + 1) % 2, xv[i], xw[i], lat);

    // Contention after reset: pointer restarts so requester 0 wins first.
    do_reset();
    value_i = {16'd7, 16'd42};
    q.push_back('{0, 20'h00042});
    q.push_back('{1, 20'h00007});
    q.push_back('{0, 20'h00042});
    req_i = 2'b11;
    for (int n = 0; n < 3; n++) begin
      bnd = 0;
      do begin @(negedge clk); bnd++; end while (ack_o == '0 && bnd < LAT_MAX + 4);
      if (ack_o == '0) begin
        ncmp++; nerr++;
        $display("FAIL contention_timeout: got no ack expected ack %0d", n);
      end
      tack[n] = cyc;
    end
    @(posedge clk); #1 req_i = '0;
    chk("contention_gap1", tack[1] - tack[0], 18);
    chk("contention_gap2", tack[2] - tack[1], 18);

    // Operand captured at grant; later value_i changes are ignored.
    value_i[16 +: 16] = 16'd500;
    q.push_back('{1, 20'h00500});
    req_i[1] = 1'b1;
    bnd = 0;
    do begin @(negedge clk); bnd++; end while (!busy_o && bnd < 10);
    @(posedge clk); @(posedge clk); #1 value_i[16 +: 16] = 16'd600;
    wait_ack(1, lat);
    @(posedge clk); #1 req_i[1] = 1'b0;

    // Reset in the middle of SHIFT drops the conversion without an ack.
    value_i[15:0] = 16'd1234;
    req_i[0] = 1'b1;
    bnd = 0;
    do begin @(negedge clk); bnd++; end while (!busy_o && bnd < 10);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy_o), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_done", 32'(done_o), 0);
    chk("mid_rst_ack", 32'(ack_o), 0);
    chk("mid_rst_bcd", 32'(bcd_o), 0);
    chk("mid_rst_id", 32'(result_id_o), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    q.push_back('{0, 20'h01234});
    wait_ack(0, lat);
    @(posedge clk); #1 req_i[0] = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      int k;
      logic [15:0] v;
      k = $urandom_range(0, NREQ - 1);
      v = 16'($urandom_range(0, 65535));
      req1(k, v, ref_bcd(int'(v)), lat);
      chk("rand_lat_bound", 32'(lat <= LAT_MAX), 1);
    end

    bnd = 0;
    while (q.size() != 0 && bnd < 50) begin @(negedge clk); bnd++; end
    if (q.size() != 0) begin
      ncmp++; nerr++;
      $display("FAIL drain: got %0d results outstanding expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/bcd_convert_scheduler.md
# bcd_convert_scheduler

Shared, sequential binary-to-BCD conversion engine with a round-robin front end. Up to NREQ game-logic clients (score, timer, lives counters) request conversion of a 16-bit unsigned value and receive a five-digit packed BCD result. The block time-multiplexes one shift-and-add-3 datapath, one bit per cycle, instead of replicating a combinational converter per display field. It sits between the game state registers and the 7-segment/HUD digit drivers.

## Interface
- NREQ, 2: number of requesters; supported range 2..4.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_i  in  NREQ  per-requester conversion request; level, held until ack.
- value_i  in  16*NREQ  requester k's operand in bits [16k+15:16k]; stable while req_i[k] high.
- ack_o  out  NREQ  one-cycle pulse to the requester whose result is on bcd_o.
- done_o  out  1  one-cycle pulse; bcd_o/result_id_o valid in this cycle.
- result_id_o  out  2  index of requester served; held until next done.
- bcd_o  out  20  {ten-thousands, thousands, hundreds, tens, ones}, 4 bits each; held until next done.
- busy_o  out  1  high in SHIFT and DONE states.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if any req_i bit high, grant one requester (round-robin), capture its value_i into the 16-bit operand shift register, clear the 20-bit digit register, clear bit counter, go SHIFT. No request: stay IDLE.
- Round-robin: pointer holds last-granted index; search starts at pointer+1 modulo NREQ. Reset value of pointer is NREQ-1, so requester 0 wins the first tie.
- SHIFT: each cycle, every digit nibble >= 5 gets +3, then the 36-bit {digits, operand} register shifts left by 1 (operand MSB first). Counter 0..15; on count 15 go DONE.
- DONE: load bcd_o from digit register, set result_id_o, pulse done_o and ack_o[granted]; go IDLE next cycle.
- Width rule: 16-bit input max 65535 fits five digits; no overflow case, no saturation.
- Requester dropping req_i mid-conversion: conversion completes; done_o and ack_o still pulse; requester ignores.
- Requester must deassert req_i on the edge following its ack_o; holding it high requests a fresh conversion, arbitrated normally.
- value_i changes while granted are irrelevant: operand captured at grant.

## Timing
- Grant edge E (IDLE samples req). Shifts on edges E+1..E+16. done_o/ack_o high in the cycle between E+16 and E+17. IDLE again after E+17; next grant earliest at E+18.
- Latency req-sampled to done: 17 cycles; throughput: one conversion per 18 cycles under continuous load.
- Reset (any time, including mid-SHIFT): state IDLE, ack_o=0, done_o=0, busy_o=0, bcd_o=20'h00000, result_id_o=0, pointer=NREQ-1; in-flight conversion discarded, no ack issued.
- Simultaneous requests: exactly one granted per IDLE cycle; never two ack bits high together.

## Structure
- Package bcd_sched_pkg: state enum (IDLE/SHIFT/DONE), constants BIN_W=16, DIGITS=5, BCD_W=20, SHIFT_LAST=15.
- Sub-module bcd_rr_arbiter: combinational grant from req vector and pointer, plus registered pointer update on grant; parameterised by NREQ.
- Add-3 adjust is an inline loop over DIGITS nibbles; no separate module.

## Test plan
- Single request: req_i=01, value 16'd1234 -> done_o after 17 cycles, bcd_o=20'h01234, result_id_o=0, ack_o=01 for one cycle.
- Extremes: 16'd0 -> 20'h00000; 16'd65535 -> 20'h65535; 16'd999 -> 20'h00999; 16'd10000 -> 20'h10000.
- Contention: req_i=11 held from reset, values 16'd42 and 16'd7 -> first done id 0 bcd 20'h00042, next done id 1 bcd 20'h00007, 18 cycles apart; continued holding alternates 0,1,0.
- Operand capture: change value_i[0] from 16'd500 to 16'd600 two cycles after grant -> result 20'h00500.
- Reset mid-SHIFT: assert rst_n low at shift cycle 8 -> outputs zero immediately, no ack; after release with req still high, fresh conversion completes correctly.
- Random: 1000 random values over random requesters vs reference model; check each requester gets ack within NREQ*18 cycles of asserting req.
